// File: rtl/led_frame_streamer_pkg.sv
// Shared types and constants for the Game of Life display path.
// This package holds the memory op codes, the streamer states and the board geometry.
package cgol_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND,
        LATCH,
        DONE
    } streamer_state_t;

    localparam int GRID_W         = 8;
    localparam int GRID_H         = 8;
    localparam int BITS_PER_PIXEL = 24;
    localparam int ADDR_W         = $clog2(GRID_W * GRID_H);

endpackage

// File: rtl/led_frame_streamer_pixel_addr_map.sv
// Maps a logical pixel index to the physical cell address for the LED matrix wiring.
// With SERPENTINE_MAP_EN defined, odd rows are column-reversed for zig-zag matrices.
module pixel_addr_map
    import cgol_pkg::*;
(
    input  logic [ADDR_W-1:0] i_pixel,
    output logic [ADDR_W-1:0] o_address
);

`ifdef SERPENTINE_MAP_EN
    localparam int COL_W = $clog2(GRID_W);

    logic [ADDR_W-COL_W-1:0] w_row;
    logic [COL_W-1:0]        w_col;

    assign w_row = i_pixel[ADDR_W-1:COL_W];
    assign w_col = i_pixel[COL_W-1:0];

    // Odd rows run right-to-left on a zig-zag strip.
    assign o_address = w_row[0] ? {w_row, ~w_col} : i_pixel;
`else
    assign o_address = i_pixel;
`endif

endmodule

// File: rtl/led_frame_streamer.sv
// Streams the 8x8 board as 24-bit GRB colours to the ws2812b bit driver, then holds the latch gap.
// The SERPENTINE_MAP_EN macro selects zig-zag addressing inside pixel_addr_map.
module led_frame_streamer
    import cgol_pkg::*;
#(
    parameter logic [23:0] ALIVE_COLOR  = 24'h00_20_00,
    parameter logic [23:0] DEAD_COLOR   = 24'h00_00_00,
    parameter int          NUM_PIXELS   = 64,
    parameter int          LATCH_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        mem_operation,
    output logic [ADDR_W-1:0] mem_address,
    input  logic              mem_data,
    output logic              serial_out,
    output logic              transmit,
    input  logic              shift
);

    localparam int PIX_W   = $clog2(NUM_PIXELS);
    localparam int BIT_W   = $clog2(BITS_PER_PIXEL + 1);
    localparam int LATCH_W = $clog2(LATCH_CYCLES + 1);

    streamer_state_t                 r_state;
    mem_op_t                         r_mem_op;
    logic [PIX_W-1:0]                r_pixel;
    logic [BIT_W-1:0]                r_bit;
    logic [LATCH_W-1:0]              r_latch;
    logic [BITS_PER_PIXEL-1:0]       r_shift;
    logic                            r_transmit;
    logic                            r_busy;
    logic                            r_done;
    logic [ADDR_W-1:0]               w_address;

    pixel_addr_map u_addr_map (
        .i_pixel   (ADDR_W'(r_pixel)),
        .o_address (w_address)
    );

    assign mem_operation = r_mem_op;
    assign mem_address   = w_address;
    assign serial_out    = r_shift[BITS_PER_PIXEL-1];
    assign transmit      = r_transmit;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

    // Start requests are only honoured in IDLE, so a start during a frame falls through untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mem_op   <= MEM_IDLE;
            r_pixel    <= '0;
            r_bit      <= '0;
            r_latch    <= '0;
            r_shift    <= '0;
            r_transmit <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state  <= FETCH;
                        r_pixel  <= '0;
                        r_mem_op <= MEM_READ;
                        r_busy   <= 1'b1;
                    end
                end
                FETCH: begin
                    r_mem_op <= MEM_IDLE;
                    r_state  <= WAIT;
                end
                WAIT: begin
                    r_shift    <= mem_data ? ALIVE_COLOR : DEAD_COLOR;
                    r_bit      <= '0;
                    r_transmit <= 1'b1;
                    r_state    <= SEND;
                end
                SEND: begin
                    if (shift) begin
                        r_shift <= {r_shift[BITS_PER_PIXEL-2:0], 1'b0};
                        r_bit   <= r_bit + BIT_W'(1);
                        if (r_bit == BIT_W'(BITS_PER_PIXEL - 1)) begin
                            r_transmit <= 1'b0;
                            if (r_pixel == PIX_W'(NUM_PIXELS - 1)) begin
                                r_latch <= '0;
                                r_state <= LATCH;
                            end else begin
                                r_pixel  <= r_pixel + PIX_W'(1);
                                r_mem_op <= MEM_READ;
                                r_state  <= FETCH;
                            end
                        end
                    end
                end
                LATCH: begin
                    if (r_latch == LATCH_W'(LATCH_CYCLES - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_latch <= r_latch + LATCH_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
